// File: rtl/receiver_pulse_decoder_pkg.sv
// Shared receiver-channel constants and the pulse-to-command scaling helper.
// Every receiver channel decoder imports this package.
package receiver_pulse_decoder_pkg;

    localparam int REC_VAL_BIT_WIDTH = 8;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [7:0] BYTE_ALL_ZERO = 8'h00;

    localparam int REC_MIN_PULSE_US = 1000;
    localparam int REC_MAX_PULSE_US = 2000;
    localparam int REC_MIN_VALID_US = 800;
    localparam int REC_MAX_VALID_US = 2200;
    localparam int REC_TIMEOUT_US   = 25000;

    localparam int WIDTH_CNT_W   = 12;
    localparam int TIMEOUT_CNT_W = 15;

    // Clamp to [lo, hi], then divide by 4: a 1000 us span maps onto 0..250.
    function automatic logic [WIDTH_CNT_W-1:0] scale_width(
        input logic [WIDTH_CNT_W-1:0] w,
        input logic [WIDTH_CNT_W-1:0] lo,
        input logic [WIDTH_CNT_W-1:0] hi
    );
        logic [WIDTH_CNT_W-1:0] c;
        c = w;
        if (w < lo)
            c = lo;
        else if (w > hi)
            c = hi;
        return (c - lo) >> 2;
    endfunction

endpackage

// File: rtl/receiver_pulse_decoder_pwm_edge_sync.sv
// Two-flop synchronizer for a raw receiver channel, plus a previous-value
// register that yields single-cycle rise/fall indications.
module pwm_edge_sync (
    input  logic us_clk,
    input  logic resetn,
    input  logic pwm_in,
    output logic sync_level,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    // Reset to high so a pulse already in progress at reset release is
    // never mistaken for a fresh rising edge.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pwm_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_level = sync_q;
    assign rise       = sync_q & ~prev_q;
    assign fall       = ~sync_q & prev_q;

endmodule

// File: rtl/receiver_pulse_decoder.sv
// Measures one RC PWM channel's high time on the 1 MHz clock, scales it to a
// 0..250 command with a valid strobe, and forces zero on loss of signal.
module receiver_pulse_decoder
    import receiver_pulse_decoder_pkg::*;
#(
    parameter int REC_VAL_BIT_WIDTH = receiver_pulse_decoder_pkg::REC_VAL_BIT_WIDTH,
    parameter int MIN_PULSE_US      = REC_MIN_PULSE_US,
    parameter int MAX_PULSE_US      = REC_MAX_PULSE_US,
    parameter int MIN_VALID_US      = REC_MIN_VALID_US,
    parameter int MAX_VALID_US      = REC_MAX_VALID_US,
    parameter int TIMEOUT_US        = REC_TIMEOUT_US
) (
    input  logic                         us_clk,
    input  logic                         resetn,
    input  logic                         pwm_in,
    output logic [REC_VAL_BIT_WIDTH-1:0] value_out,
    output logic                         value_valid,
    output logic                         signal_lost,
    output logic                         reject_pulse
);

    typedef enum logic [4:0] {
        ST_WAIT_LOW  = 5'b00001,
        ST_WAIT_RISE = 5'b00010,
        ST_MEASURE   = 5'b00100,
        ST_CONVERT   = 5'b01000,
        ST_PUBLISH   = 5'b10000
    } state_t;

    localparam logic [WIDTH_CNT_W-1:0]   MIN_PULSE_W = WIDTH_CNT_W'(MIN_PULSE_US);
    localparam logic [WIDTH_CNT_W-1:0]   MAX_PULSE_W = WIDTH_CNT_W'(MAX_PULSE_US);
    localparam logic [WIDTH_CNT_W-1:0]   MIN_VALID_W = WIDTH_CNT_W'(MIN_VALID_US);
    localparam logic [WIDTH_CNT_W-1:0]   MAX_VALID_W = WIDTH_CNT_W'(MAX_VALID_US);
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_C   = TIMEOUT_CNT_W'(TIMEOUT_US);

    logic sync_level, rise, fall;

    pwm_edge_sync u_sync (
        .us_clk     (us_clk),
        .resetn     (resetn),
        .pwm_in     (pwm_in),
        .sync_level (sync_level),
        .rise       (rise),
        .fall       (fall)
    );

    state_t                         state_q;
    logic [WIDTH_CNT_W-1:0]         width_q, width_d, scaled;
    logic [TIMEOUT_CNT_W-1:0]       to_q, to_d;
    logic [REC_VAL_BIT_WIDTH-1:0]   value_q;
    logic                           valid_q, reject_q, lost_q;
    logic                           accept, timeout_hit;

    assign width_d     = (&width_q) ? width_q : width_q + 1'b1;
    assign to_d        = (to_q == TIMEOUT_C) ? to_q : to_q + 1'b1;
    assign scaled      = scale_width(width_q, MIN_PULSE_W, MAX_PULSE_W);
    assign accept      = (state_q == ST_CONVERT) && (width_q >= MIN_VALID_W);
    assign timeout_hit = (to_d == TIMEOUT_C) && (to_q != TIMEOUT_C);

    // Outputs are registered on the CONVERT->PUBLISH edge so the strobe is
    // visible during the PUBLISH cycle, two cycles after the fall is seen.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_WAIT_LOW;
            width_q  <= '0;
            to_q     <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            to_q     <= to_d;
            case (state_q)
                ST_WAIT_LOW: begin
                    if (!sync_level)
                        state_q <= ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        width_q <= WIDTH_CNT_W'(1);
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (fall) begin
                        state_q <= ST_CONVERT;
                    end else if (sync_level) begin
                        width_q <= width_d;
                        if (width_q == MAX_VALID_W) begin
                            reject_q <= 1'b1;
                            state_q  <= ST_WAIT_LOW;
                        end
                    end
                end
                ST_CONVERT: begin
                    if (accept) begin
                        value_q <= REC_VAL_BIT_WIDTH'(scaled);
                        valid_q <= 1'b1;
                        lost_q  <= 1'b0;
                        to_q    <= '0;
                        state_q <= ST_PUBLISH;
                    end else begin
                        reject_q <= 1'b1;
                        state_q  <= ST_WAIT_RISE;
                    end
                end
                ST_PUBLISH: state_q <= ST_WAIT_RISE;
                default:    state_q <= ST_WAIT_LOW;
            endcase
            // An accepted pulse in the same cycle takes priority over loss.
            if (timeout_hit && !lost_q && !accept) begin
                lost_q  <= 1'b1;
                value_q <= '0;
                valid_q <= 1'b1;
            end
        end
    end

    assign value_out    = value_q;
    assign value_valid  = valid_q;
    assign signal_lost  = lost_q;
    assign reject_pulse = reject_q;

endmodule

// File: doc/receiver_pulse_decoder.md
# receiver_pulse_decoder

Measures the high time of one RC-receiver PWM channel on the 1 MHz us_clk, converts 1000–2000 µs pulses to a 0–250 command value, and presents it with a one-cycle valid strobe. It sits directly upstream of the throttle controller (and of the identical yaw/roll/pitch channel consumers). value_out drives the throttle controller's input value, and value_valid drives its start_signal. It also detects loss of receiver signal and forces a zero command when the signal is lost.

## Interface
- REC_VAL_BIT_WIDTH, 8: output value width.
- MIN_PULSE_US, 1000: pulse width mapped to 0.
- MAX_PULSE_US, 2000: pulse width mapped to 250.
- MIN_VALID_US, 800: shorter pulses rejected as glitches.
- MAX_VALID_US, 2200: longer pulses rejected as stuck-high or garbage.
- TIMEOUT_US, 25000: µs without an accepted pulse before signal is declared lost.
- us_clk, input, 1: 1 MHz system microsecond clock.
- resetn, input, 1: asynchronous, active-low reset.
- pwm_in, input, 1: raw receiver channel; asynchronous to us_clk.
- value_out, output, REC_VAL_BIT_WIDTH: scaled command, 0–250.
- value_valid, output, 1: one-cycle strobe; value_out is new on this cycle.
- signal_lost, output, 1: high while no accepted pulse within TIMEOUT_US.
- reject_pulse, output, 1: one-cycle strobe when a pulse is discarded.

## Operation
- pwm_in passes through a 2-flop synchronizer. A rise is sync=1 with prev=0; a fall is sync=0 with prev=1.
- States:
  - WAIT_LOW (reset state): wait for sync==0. This discards any partial pulse present at reset. Then go to WAIT_RISE.
  - WAIT_RISE: on rise, clear width_cnt to 1 and go to MEASURE.
  - MEASURE: increment width_cnt each cycle sync==1.
    - On fall, go to CONVERT.
    - If width_cnt reaches MAX_VALID_US+1 while high, pulse reject_pulse and go to WAIT_LOW.
  - CONVERT: if width_cnt < MIN_VALID_US, pulse reject_pulse and go to WAIT_RISE. Otherwise compute scaled and go to PUBLISH.
  - PUBLISH: value_out <= scaled, value_valid=1, signal_lost <= 0, clear timeout counter, go to WAIT_RISE.
- Scaling:
  - w = width_cnt clamped to [MIN_PULSE_US, MAX_PULSE_US].
  - scaled = (w − MIN_PULSE_US) >> 2. This gives 1000→0, 1500→125, 2000→250.
  - Do all arithmetic in a 12-bit unsigned width, then truncate to REC_VAL_BIT_WIDTH. The result never exceeds 250.
- width_cnt: 12 bits, saturating, never wraps.
- Timeout counter:
  - 15 bits, saturating at TIMEOUT_US.
  - Increments every cycle, regardless of state.
  - Cleared only in PUBLISH.
- On the cycle the timeout counter reaches TIMEOUT_US while signal_lost==0:
  - signal_lost <= 1, value_out <= 0, value_valid=1 (single strobe).
  - The strobe fires once per loss event; no further strobes until a pulse is accepted.
- Simultaneous PUBLISH and timeout in the same cycle: PUBLISH wins. value_out is scaled, signal_lost stays 0, and one strobe is emitted.
- Rejected pulses do not clear the timeout counter.

## Timing
- Reset values:
  - value_out=0, value_valid=0, reject_pulse=0.
  - signal_lost=1 (no signal yet; no timeout strobe is issued from reset).
  - State WAIT_LOW; all counters 0.
- Measured width equals true high time ±1 cycle. Synchronizer delay cancels between the rise and the fall.
- Latency: value_valid is asserted 2 cycles after the cycle the synchronized fall is detected (MEASURE→CONVERT→PUBLISH). This is 4 cycles after the pwm_in falling edge.
- value_out holds between strobes. Consumers may sample it any time; the new value is guaranteed on the strobe cycle.
- value_valid and reject_pulse are never high in the same cycle.
- Minimum accepted frame rate is MAX_VALID_US+4 cycles. A rise arriving during CONVERT/PUBLISH is missed, and that pulse is measured only from the next rise.
- Asserting resetn mid-pulse aborts the measurement. After release, the block waits in WAIT_LOW until pwm_in goes low.

## Structure
- Shared constants in common_defines.v:
  - REC_VAL_BIT_WIDTH, TRUE/FALSE, BYTE_ALL_ZERO.
  - Receiver pulse limits (1000/2000/800/2200 µs) and the default timeout.
  - State one-hot encodings stay local.
- One sub-module, pwm_edge_sync: 2-flop synchronizer plus previous-value register; outputs sync_level, rise, fall. Reused by all receiver channels.

## Test plan
- 1500 µs pulse after 500 µs low → value_out=125, value_valid one cycle, 4 cycles after the falling edge; signal_lost drops 1→0.
- 1000, 2000, 950, 2100 µs pulses → 0, 250, 0 (clamped), 250 (clamped), each with a strobe.
- 500 µs pulse → reject_pulse strobe, value_out unchanged, no value_valid. 3000 µs high → reject_pulse at count 2201, then resync on the next low.
- Accepted pulse, then pwm_in held low 25000 µs → single strobe with value_out=0, signal_lost=1. No further strobes; the next 1200 µs pulse gives 50 and signal_lost=0.
- pwm_in high at reset release, falling 700 µs later, then a 1800 µs pulse → the first partial pulse is ignored and the output is 200.
- resetn asserted during a 1600 µs pulse → all outputs return to reset values immediately. That pulse produces no strobe after release.
